// File: rtl/comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// encoded compare result that the top decodes onto ls/gr/eq.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMP_NONE = 2'd0,
    CMP_LS   = 2'd1,
    CMP_GR   = 2'd2,
    CMP_EQ   = 2'd3
  } cmp_result_t;

  // Resolve a final result from the sticky decision and the current bit.
  function automatic cmp_result_t resolve(input logic decided, input logic a_greater);
    cmp_result_t r;
    r = CMP_EQ;
    if (decided) r = a_greater ? CMP_GR : CMP_LS;
    return r;
  endfunction

endpackage

// File: rtl/serial_bit_cmp.sv
// One-bit MSB-first compare step with a sticky "decided" flag that
// remembers which operand won at the first differing bit.
module serial_bit_cmp (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a_bit,
  input  logic b_bit,
  output logic decided,
  output logic a_gt,
  output logic diff
);

  assign diff = en && !decided && (a_bit ^ b_bit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      decided <= 1'b0;
      a_gt    <= 1'b0;
    end else if (diff) begin
      decided <= 1'b1;
      a_gt    <= a_bit;
    end
  end

endmodule

// File: rtl/serial_comparator.sv
// Handshaked MSB-first serial magnitude comparator with one-hot ls/gr/eq.
// Define EARLY_EXIT_EN to finish on the first differing bit (data-dependent latency).
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// SHIFT | comparing one bit per cycle, MSB first
// DONE  | out_valid=1, result held until out_ready
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ls,
  output logic             gr,
  output logic             eq
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t           state;
  cmp_result_t      res;
  cmp_result_t      res_final;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;
  logic             shifting;
  logic             decided;
  logic             dec_gt;
  logic             diff_now;
  logic             finish;

  assign accept   = in_valid && (state == IDLE);
  assign shifting = (state == SHIFT);
  assign cnt_nxt  = cnt + 1'b1;

  serial_bit_cmp u_bit_cmp (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (shifting),
    .a_bit   (sh_a[WIDTH-1]),
    .b_bit   (sh_b[WIDTH-1]),
    .decided (decided),
    .a_gt    (dec_gt),
    .diff    (diff_now)
  );

  // A decision already latched wins over whatever the current MSB says.
  always_comb begin
    res_final = resolve(decided || diff_now, decided ? dec_gt : sh_a[WIDTH-1]);
  end

`ifdef EARLY_EXIT_EN
  assign finish = shifting && (diff_now || (cnt_nxt == LAST));
`else
  assign finish = shifting && (cnt_nxt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res   <= CMP_NONE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a  <= a;
            sh_b  <= b;
            cnt   <= '0;
            res   <= CMP_NONE;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sh_a <= sh_a << 1;
          sh_b <= sh_b << 1;
          cnt  <= cnt_nxt;
          if (finish) begin
            res   <= res_final;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            res   <= CMP_NONE;
            state <= IDLE;
          end
        end
        default: begin
          res   <= CMP_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign ls        = (res == CMP_LS);
  assign gr        = (res == CMP_GR);
  assign eq        = (res == CMP_EQ);

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator; expected latency follows EARLY_EXIT_EN.
module tb_serial_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic         ls;
  logic         gr;
  logic         eq;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ls        (ls),
    .gr        (gr),
    .eq        (eq)
  );

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_res = 0;
  int   n_sent = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    int   k;
    k = -1;
    for (int i = W - 1; i >= 0; i--) begin
      if (k < 0 && x[i] != y[i]) k = W - 1 - i;
    end
    if (x < y)      r.res = 3'b100;
    else if (x > y) r.res = 3'b010;
    else            r.res = 3'b001;
`ifdef EARLY_EXIT_EN
    r.lat = (k >= 0) ? k + 1 : W;
`else
    r.lat = W;
`endif
    r.acc = 0;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  logic       prev_ov = 1'b0;
  logic       hs_pend = 1'b0;
  logic [2:0] held = 3'b000;

  // Monitor: pushes on accept, pops and checks when out_valid rises.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      prev_ov <= 1'b0;
      hs_pend <= 1'b0;
    end else begin
      if (hs_pend) begin
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);
      end
      if (!out_valid) chk("idle_flags", {ls, gr, eq}, 0);
      if (out_valid) chk("busy_in_ready", in_ready, 0);
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          e = q.pop_front();
          n_res++;
          chk("result_lsgreq", {ls, gr, eq}, e.res);
          chk("latency", cyc - e.acc, e.lat);
          held <= {ls, gr, eq};
        end
      end else if (out_valid) begin
        chk("held_result", {ls, gr, eq}, held);
      end
      if (in_valid && in_ready) begin
        e = model(a, b);
        e.acc = cyc + 1;
        q.push_back(e);
        n_acc++;
      end
      hs_pend <= out_valid && out_ready;
      prev_ov <= out_valid;
    end
  end

  // Callers are aligned #1 after a rising edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
    in_valid = 1'b1;
    a = x;
    b = y;
    n_sent++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid && in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pairs [0:9];
    int ok;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {ls, gr, eq}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(8'd120, 8'd200, 0); wait_idle();
    send(8'd150, 8'd100, 0); wait_idle();
    send(8'd55, 8'd55, 0);   wait_idle();

    // Backpressure: hold result for 5 cycles.
    out_ready = 1'b0;
    send(8'd7, 8'd6, 0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    chk("bp_out_valid_seen", ok, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_gr", gr, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset mid-SHIFT aborts the transaction.
    send(8'd0, 8'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (12) @(posedge clk);
    #1;
    send(8'd1, 8'd2, 0); wait_idle();

    // Back-to-back with in_valid held high.
    send(8'd255, 8'd0, 1);
    send(8'd0, 8'd255, 1);
    send(8'd128, 8'd128, 0);
    wait_idle();

    // Boundaries: LSB-only difference, extremes, equal extremes.
    pairs = '{8'd0, 8'd1, 8'd254, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd129, 8'd128};
    for (int i = 0; i < 10; i += 2) begin
      send(pairs[i], pairs[i+1], 0);
      wait_idle();
    end

    for (int i = 0; i < 20; i++) begin
      send(W'($urandom_range(255)), W'($urandom_range(255)), i[0]);
    end
    in_valid = 1'b0;
    wait_idle();

    chk("queue_empty", q.size(), 0);
    chk("accepted_count", n_acc, n_sent);
    chk("result_count", n_res, n_sent - 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
